multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle RV32I-subset core. Sequences the shared datapath (PC, IR, register file, single ALU, unified memory) through fetch/decode/execute/memory/writeback, issuing one ALU operation per cycle. It drives the ALU-select mux codes and a 2-bit `alu_op` to the ALU control decoder. It waits on a `mem_ready` handshake for every memory access.

---
 rtl/multicycle_ctrl.sv | 152 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM sequencing the shared multicycle RV32I-subset datapath.
// Strobes are held low while rst_i is high; mux codes follow the FETCH state during reset.
module multicycle_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       branch_o,
    output logic       ir_write_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       adr_src_o,
    output logic       reg_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] result_src_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t state_q, state_d;
    logic pc_write, branch, ir_write, mem_read, mem_write, adr_src, reg_write, instr_done, illegal;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = FETCH;
        pc_write     = 1'b0;
        branch       = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        adr_src      = 1'b0;
        reg_write    = 1'b0;
        instr_done   = 1'b0;
        illegal      = 1'b0;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        result_src_o = 2'b00;
        case (state_q)
            FETCH: begin
                mem_read     = 1'b1;
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                ir_write     = mem_ready_i;
                pc_write     = mem_ready_i;
                state_d      = mem_ready_i ? DECODE : FETCH;
            end
            DECODE: begin
                // ALUOut captures oldPC+imm as the branch/jump target
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                case (opcode_i)
                    OP_R:         state_d = EXEC_R;
                    OP_I:         state_d = EXEC_I;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_JAL:       state_d = JAL;
                    default:      illegal = 1'b1;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                state_d     = (opcode_i == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
                state_d  = mem_ready_i ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                reg_write    = 1'b1;
                result_src_o = 2'b01;
                instr_done   = 1'b1;
            end
            MEM_WR: begin
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                instr_done = mem_ready_i;
                state_d    = mem_ready_i ? FETCH : MEM_WR;
            end
            EXEC_R: begin
                alu_src_a_o = 2'b10;
                alu_op_o    = 2'b10;
                state_d     = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                alu_op_o    = 2'b11;
                state_d     = ALU_WB;
            end
            ALU_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a_o = 2'b10;
                alu_op_o    = 2'b01;
                branch      = 1'b1;
                instr_done  = 1'b1;
            end
            JAL: begin
                // ALU computes oldPC+4 for rd while PC loads the target from ALUOut
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                pc_write    = 1'b1;
                state_d     = ALU_WB;
            end
            default: state_d = FETCH;
        endcase
    end

    assign pc_write_o   = pc_write & ~rst_i;
    assign branch_o     = branch & ~rst_i;
    assign ir_write_o   = ir_write & ~rst_i;
    assign mem_read_o   = mem_read & ~rst_i;
    assign mem_write_o  = mem_write & ~rst_i;
    assign adr_src_o    = adr_src;
    assign reg_write_o  = reg_write & ~rst_i;
    assign instr_done_o = instr_done & ~rst_i;
    assign illegal_o    = illegal & ~rst_i;
    assign state_o      = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scenario checks of the multicycle control FSM.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write, branch, ir_write, mem_read, mem_write, adr_src, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       instr_done, illegal;
    logic [3:0] state;
    int errors = 0;
    int checks = 0;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    multicycle_ctrl dut (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .pc_write_o(pc_write), .branch_o(branch), .ir_write_o(ir_write),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .adr_src_o(adr_src),
        .reg_write_o(reg_write), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
        .alu_op_o(alu_op), .result_src_o(result_src), .instr_done_o(instr_done),
        .illegal_o(illegal), .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; opcode = OP_LW;
        tick(); tick();
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++;
        if ({pc_write, ir_write, mem_read, instr_done, illegal} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes got=%b exp=00000", {pc_write, ir_write, mem_read, instr_done, illegal});
        end
        checks++;
        if ({alu_src_b, result_src} !== 4'b1010) begin errors++; $display("FAIL reset_mux got=%b exp=1010", {alu_src_b, result_src}); end
        rst = 1'b0;
        #1;
        checks++;
        if ({ir_write, pc_write, mem_read} !== 3'b111) begin errors++; $display("FAIL release_fetch got=%b exp=111", {ir_write, pc_write, mem_read}); end
        tick(); tick(); mem_ready = 1'b0; tick();
        checks++;
        if ({state, mem_read, adr_src} !== {4'd3, 2'b11}) begin
            errors++; $display("FAIL reach_memrd got=%0d/%b%b exp=3/11", state, mem_read, adr_src);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL async_reset_state got=%0d exp=0", state); end
        checks++;
        if ({pc_write, branch, ir_write, mem_read, mem_write, reg_write, instr_done, illegal} !== 8'b0) begin
            errors++; $display("FAIL async_reset_strobes got=%b exp=0", {pc_write, branch, ir_write, mem_read, mem_write, reg_write, instr_done, illegal});
        end
        mem_ready = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({state, ir_write, pc_write} !== {4'd0, 2'b11}) begin
            errors++; $display("FAIL post_reset_fetch got=%0d/%b%b exp=0/11", state, ir_write, pc_write);
        end
        tick();
        checks++;
        if (state !== 4'd1) begin errors++; $display("FAIL post_reset_decode got=%0d exp=1", state); end
        rst = 1'b1; #1; rst = 1'b0; #1;
    endtask

    task automatic test_rtype();
        int  exp_st[5] = '{0, 1, 6, 8, 0};
        bit  rdy[5]    = '{1, 0, 0, 0, 1};
        opcode = OP_R;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (state !== exp_st[i][3:0]) begin errors++; $display("FAIL r_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]); end
            checks++;
            if (instr_done !== (i == 3)) begin errors++; $display("FAIL r_done[%0d] got=%b exp=%b", i, instr_done, i == 3); end
            checks++;
            if (reg_write !== (exp_st[i] == 8)) begin errors++; $display("FAIL r_regw[%0d] got=%b", i, reg_write); end
            if (exp_st[i] == 6) begin
                checks++;
                if ({alu_op, alu_src_a, alu_src_b} !== 6'b10_10_00) begin
                    errors++; $display("FAIL r_exec_mux got=%b exp=101000", {alu_op, alu_src_a, alu_src_b});
                end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_itype();
        int exp_st[5] = '{0, 1, 7, 8, 0};
        opcode = OP_I; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state !== exp_st[i][3:0]) begin errors++; $display("FAIL i_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]); end
            if (exp_st[i] == 7) begin
                checks++;
                if ({alu_op, alu_src_a, alu_src_b} !== 6'b11_10_01) begin
                    errors++; $display("FAIL i_exec_mux got=%b exp=111001", {alu_op, alu_src_a, alu_src_b});
                end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_lw_wait();
        int exp_st[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
        bit rdy[9]    = '{1, 1, 0, 0, 0, 0, 1, 0, 1};
        opcode = OP_LW;
        for (int i = 0; i < 9; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (state !== exp_st[i][3:0]) begin errors++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]); end
            checks++;
            if ({mem_read, adr_src} !== {exp_st[i] == 0 || exp_st[i] == 3, exp_st[i] == 3}) begin
                errors++; $display("FAIL lw_req[%0d] got=%b%b", i, mem_read, adr_src);
            end
            checks++;
            if (reg_write !== (exp_st[i] == 4)) begin errors++; $display("FAIL lw_regw[%0d] got=%b", i, reg_write); end
            checks++;
            if (instr_done !== (exp_st[i] == 4)) begin errors++; $display("FAIL lw_done[%0d] got=%b", i, instr_done); end
            if (exp_st[i] == 4) begin
                checks++;
                if (result_src !== 2'b01) begin errors++; $display("FAIL lw_result_src got=%b exp=01", result_src); end
            end
            if (i < 8) tick();
        end
    endtask

    task automatic test_back_to_back();
        int exp_st[8] = '{0, 1, 2, 5, 0, 1, 9, 0};
        opcode = OP_SW; mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) opcode = OP_BEQ;
            #1;
            checks++;
            if (state !== exp_st[i][3:0]) begin errors++; $display("FAIL b2b_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]); end
            checks++;
            if (mem_write !== (exp_st[i] == 5)) begin errors++; $display("FAIL b2b_memw[%0d] got=%b", i, mem_write); end
            checks++;
            if (branch !== (exp_st[i] == 9)) begin errors++; $display("FAIL b2b_branch[%0d] got=%b", i, branch); end
            checks++;
            if (pc_write !== (exp_st[i] == 0)) begin errors++; $display("FAIL b2b_pcw[%0d] got=%b", i, pc_write); end
            checks++;
            if (instr_done !== (exp_st[i] == 5 || exp_st[i] == 9)) begin errors++; $display("FAIL b2b_done[%0d] got=%b", i, instr_done); end
            if (exp_st[i] == 9) begin
                checks++;
                if ({alu_op, alu_src_a, alu_src_b} !== 6'b01_10_00) begin
                    errors++; $display("FAIL beq_mux got=%b exp=011000", {alu_op, alu_src_a, alu_src_b});
                end
            end
            if (i < 7) tick();
        end
    endtask

    task automatic test_jal();
        int exp_st[5] = '{0, 1, 10, 8, 0};
        opcode = OP_JAL; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state !== exp_st[i][3:0]) begin errors++; $display("FAIL jal_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]); end
            checks++;
            if (pc_write !== (exp_st[i] == 0 || exp_st[i] == 10)) begin errors++; $display("FAIL jal_pcw[%0d] got=%b", i, pc_write); end
            checks++;
            if (reg_write !== (exp_st[i] == 8)) begin errors++; $display("FAIL jal_regw[%0d] got=%b", i, reg_write); end
            checks++;
            if (instr_done !== (exp_st[i] == 8)) begin errors++; $display("FAIL jal_done[%0d] got=%b", i, instr_done); end
            if (exp_st[i] == 10) begin
                checks++;
                if ({result_src, alu_src_a, alu_src_b} !== 6'b00_01_10) begin
                    errors++; $display("FAIL jal_mux got=%b exp=000110", {result_src, alu_src_a, alu_src_b});
                end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_illegal();
        int exp_st[5] = '{0, 0, 0, 1, 0};
        bit rdy[5]    = '{0, 0, 1, 1, 1};
        opcode = 7'b1111111;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (state !== exp_st[i][3:0]) begin errors++; $display("FAIL ill_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]); end
            checks++;
            if (illegal !== (exp_st[i] == 1)) begin errors++; $display("FAIL ill_pulse[%0d] got=%b", i, illegal); end
            checks++;
            if ({ir_write, mem_read} !== {exp_st[i] == 0 && rdy[i], exp_st[i] == 0}) begin
                errors++; $display("FAIL ill_fetch[%0d] got=%b%b", i, ir_write, mem_read);
            end
            checks++;
            if ({instr_done, reg_write, mem_write} !== 3'b000) begin
                errors++; $display("FAIL ill_strobes[%0d] got=%b exp=000", i, {instr_done, reg_write, mem_write});
            end
            if (i < 4) tick();
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_lw_wait();
        test_back_to_back();
        test_jal();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
